// File: rtl/vdp_tile_row_shifter.sv
// vdp_tile_row_shifter: fetches a 4bpp tile row (two VRAM words) and shifts out palette-qualified pixels gaplessly.
// Optional saturating underrun counter enabled by VDP_TILE_UNDERRUN_COUNT_EN.
module vdp_tile_row_shifter #(
  parameter logic [7:0] TRANSPARENT_PIXEL = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [2:0]  scroll_x_granular,
  input  logic        fetch_start,
  input  logic [13:0] tile_address,
  input  logic [15:0] map_data,
  output logic        fetch_ready,
  output logic        vram_read_en,
  output logic [14:0] vram_address,
  input  logic [15:0] vram_data,
  input  logic        pixel_advance,
  output logic [7:0]  pixel,
  output logic        pixel_valid,
  output logic        underrun,
  output logic [7:0]  underrun_count
);
  typedef enum logic [1:0] {IDLE, RD0, RD1, CAP1} state_t;
  state_t state_q, state_d;
  logic [13:0] addr_q, addr_d;
  logic [3:0]  fpal_q, fpal_d, ppal_q, ppal_d, spal_q, spal_d, cnt_q, cnt_d;
  logic        fflip_q, fflip_d, pfull_q, pfull_d, pv_q, pv_d, ur_q, ur_d;
  logic [15:0] w0_q, w0_d;
  logic [31:0] pend_q, pend_d, sh_q, sh_d;
  logic [2:0]  disc_q, disc_d;
  logic [7:0]  pix_q, pix_d;
  logic [31:0] raw, row, new_sh, h_sh;
  logic [3:0]  new_cnt, h_cnt, h_pal;
  logic        accept, xfer, use_new, take, starve;
  logic        unused_map;

  assign unused_map   = ^{map_data[11], map_data[9:0]};
  assign fetch_ready  = !reset && state_q == IDLE && !pfull_q;
  assign vram_read_en = state_q == RD0 || state_q == RD1;
  assign vram_address = state_q == RD0 ? {addr_q, 1'b0} : state_q == RD1 ? {addr_q, 1'b1} : 15'd0;
  assign pixel        = pix_q;
  assign pixel_valid  = pv_q;
  assign underrun     = ur_q;

  // Leftmost pixel sits in the top nibble; flipping reverses nibble order.
  always_comb begin
    raw = {w0_q, vram_data};
    row = raw;
    if (fflip_q)
      for (int i = 0; i < 8; i++) row[28-4*i +: 4] = raw[4*i +: 4];
  end

  always_comb begin
    accept  = state_q == IDLE && fetch_start && fetch_ready;
    xfer    = pfull_q && (cnt_q == 4'd0 || (cnt_q == 4'd1 && pixel_advance));
    use_new = xfer && cnt_q == 4'd0;
    new_sh  = pend_q << {disc_q, 2'b00};
    new_cnt = 4'd8 - {1'b0, disc_q};
    h_sh    = use_new ? new_sh : sh_q;
    h_cnt   = use_new ? new_cnt : cnt_q;
    h_pal   = use_new ? ppal_q : spal_q;
    take    = pixel_advance && h_cnt != 4'd0;
    starve  = pixel_advance && h_cnt == 4'd0;
    state_d = state_q == IDLE ? (accept ? RD0 : IDLE) : state_q == RD0 ? RD1 : state_q == RD1 ? CAP1 : IDLE;
    addr_d  = accept ? tile_address : addr_q;
    fpal_d  = accept ? map_data[15:12] : fpal_q;
    fflip_d = accept ? map_data[10] : fflip_q;
    w0_d    = state_q == RD1 ? vram_data : w0_q;
    pend_d  = state_q == CAP1 ? row : pend_q;
    ppal_d  = state_q == CAP1 ? fpal_q : ppal_q;
    pfull_d = state_q == CAP1 || (pfull_q && !xfer);
    sh_d    = take ? {h_sh[27:0], 4'h0} : h_sh;
    cnt_d   = take ? h_cnt - 4'd1 : h_cnt;
    spal_d  = h_pal;
    disc_d  = xfer ? 3'd0 : disc_q;
    pix_d   = take ? {h_pal, h_sh[31:28]} : starve ? TRANSPARENT_PIXEL : pix_q;
    pv_d    = pixel_advance;
    ur_d    = ur_q || starve;
    // Last pixel of the old row leaves while the pending row loads behind it.
    if (xfer && !use_new) begin
      sh_d   = new_sh;
      cnt_d  = new_cnt;
      spal_d = ppal_q;
    end
    if (line_start) begin
      state_d = IDLE;
      pfull_d = 1'b0;
      cnt_d   = 4'd0;
      disc_d  = scroll_x_granular;
      ur_d    = 1'b0;
      pv_d    = 1'b0;
      pix_d   = TRANSPARENT_PIXEL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      fpal_q  <= '0;
      fflip_q <= 1'b0;
      w0_q    <= '0;
      pend_q  <= '0;
      ppal_q  <= '0;
      pfull_q <= 1'b0;
      sh_q    <= '0;
      spal_q  <= '0;
      cnt_q   <= '0;
      disc_q  <= '0;
      pix_q   <= TRANSPARENT_PIXEL;
      pv_q    <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      fpal_q  <= fpal_d;
      fflip_q <= fflip_d;
      w0_q    <= w0_d;
      pend_q  <= pend_d;
      ppal_q  <= ppal_d;
      pfull_q <= pfull_d;
      sh_q    <= sh_d;
      spal_q  <= spal_d;
      cnt_q   <= cnt_d;
      disc_q  <= disc_d;
      pix_q   <= pix_d;
      pv_q    <= pv_d;
      ur_q    <= ur_d;
    end
  end

`ifdef VDP_TILE_UNDERRUN_COUNT_EN
  logic [7:0] urc_q, urc_d;
  always_comb urc_d = line_start ? 8'd0 : (starve && urc_q != 8'hFF) ? urc_q + 8'd1 : urc_q;
  always_ff @(posedge clk) begin
    if (reset) urc_q <= 8'd0;
    else urc_q <= urc_d;
  end
  assign underrun_count = urc_q;
`else
  assign underrun_count = 8'h00;
`endif
endmodule

// File: tb/tb_vdp_tile_row_shifter.sv
// tb_vdp_tile_row_shifter: randomized scoreboard bench with a row-level pixel queue model.
module tb_vdp_tile_row_shifter;
  logic clk = 0, reset = 1, line_start = 0, fetch_start = 0, pixel_advance = 0;
  logic [2:0] scroll_x_granular = 0;
  logic [13:0] tile_address = 0;
  logic [15:0] map_data = 0, vram_data = 0;
  logic fetch_ready, vram_read_en, pixel_valid, underrun;
  logic [14:0] vram_address;
  logic [7:0] pixel, underrun_count;

  vdp_tile_row_shifter dut (
    .clk(clk), .reset(reset), .line_start(line_start), .scroll_x_granular(scroll_x_granular),
    .fetch_start(fetch_start), .tile_address(tile_address), .map_data(map_data),
    .fetch_ready(fetch_ready), .vram_read_en(vram_read_en), .vram_address(vram_address),
    .vram_data(vram_data), .pixel_advance(pixel_advance), .pixel(pixel),
    .pixel_valid(pixel_valid), .underrun(underrun), .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:32767];
  always @(posedge clk) vram_data <= vram_read_en ? mem[vram_address] : 16'($urandom);

  int compared = 0, mismatched = 0;
  logic [7:0] exp_q[$];
  logic [7:0] avail[$];
  int disc_m = 0, urc_m = 0;
  bit ur_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && pixel_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL pixel_unexpected: got %0h expected none", pixel);
      end else check("pixel", {24'd0, pixel}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_line(input logic [2:0] s);
    line_start = 1;
    scroll_x_granular = s;
    tick();
    line_start = 0;
    avail.delete();
    disc_m = s;
    ur_m = 0;
    urc_m = 0;
  endtask

  task automatic model_row(input logic [13:0] a, input logic [15:0] md);
    for (int i = 0; i < 8; i++) begin
      int j;
      logic [15:0] w;
      j = md[10] ? 7 - i : i;
      w = j < 4 ? mem[{a, 1'b0}] : mem[{a, 1'b1}];
      if (i >= disc_m) avail.push_back({md[15:12], 4'((w >> (12 - 4 * (j % 4))) & 16'hF)});
    end
    disc_m = 0;
  endtask

  task automatic fetch(input logic [13:0] a, input logic [15:0] md);
    int n = 0;
    while (!fetch_ready && n < 50) begin
      tick();
      n++;
    end
    check("fetch_ready_wait", {31'd0, fetch_ready}, 1);
    tile_address = a;
    map_data = md;
    fetch_start = 1;
    tick();
    fetch_start = 0;
    check("rd0_addr", {16'd0, vram_read_en, vram_address}, {16'd0, 1'b1, a, 1'b0});
    tick();
    check("rd1_addr", {16'd0, vram_read_en, vram_address}, {16'd0, 1'b1, a, 1'b1});
    tick();
    check("cap1_rd_en", {31'd0, vram_read_en}, 0);
    tick();
    model_row(a, md);
  endtask

  task automatic advance(input bit a);
    pixel_advance = a;
    if (a) begin
      if (avail.size() != 0) exp_q.push_back(avail.pop_front());
      else begin
        exp_q.push_back(8'h00);
        ur_m = 1;
        if (urc_m < 255) urc_m++;
      end
    end
    tick();
  endtask

  task automatic settle();
    pixel_advance = 0;
    tick();
    tick();
    check("underrun", {31'd0, underrun}, {31'd0, ur_m});
`ifdef VDP_TILE_UNDERRUN_COUNT_EN
    check("underrun_count", {24'd0, underrun_count}, urc_m);
`else
    check("underrun_count", {24'd0, underrun_count}, 0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[15'h0246] = 16'h1234;
    mem[15'h0247] = 16'h5678;
    tick();
    tick();
    check("reset_fetch_ready", {31'd0, fetch_ready}, 0);
    reset = 0;
    tick();
    check("reset_outputs", {vram_read_en, vram_address, pixel, pixel_valid, underrun, underrun_count},
          {1'b0, 15'd0, 8'h00, 1'b0, 1'b0, 8'h00});
    check("reset_ready", {31'd0, fetch_ready}, 1);
    // basic, x-flip, fine scroll
    fetch(14'h0123, 16'h5000);
    repeat (8) advance(1);
    settle();
    fetch(14'h0123, 16'h5400);
    repeat (8) advance(1);
    settle();
    do_line(3'd3);
    fetch(14'h0123, 16'h5000);
    repeat (5) advance(1);
    settle();
    fetch(14'h0123, 16'hA000);
    repeat (8) advance(1);
    settle();
    // gapless over two buffered rows
    do_line(3'd0);
    fetch(14'h0123, 16'h5000);
    fetch(14'h0123, 16'hA000);
    repeat (16) advance(1);
    settle();
    // underrun and saturation
    do_line(3'd0);
    advance(1);
    settle();
    repeat (300) advance(1);
    settle();
    // abort during RD1
    do_line(3'd0);
    tile_address = 14'h0123;
    map_data = 16'h5000;
    fetch_start = 1;
    tick();
    fetch_start = 0;
    tick();
    line_start = 1;
    scroll_x_granular = 0;
    tick();
    line_start = 0;
    avail.delete();
    ur_m = 0;
    urc_m = 0;
    check("abort_rd_en", {31'd0, vram_read_en}, 0);
    check("abort_ready", {31'd0, fetch_ready}, 1);
    advance(1);
    settle();
    // randomized lines
    for (int it = 0; it < 40; it++) begin
      int rows, m;
      do_line(3'($urandom_range(0, 7)));
      rows = $urandom_range(0, 2);
      for (int r = 0; r < rows; r++) fetch(14'($urandom), 16'($urandom));
      m = $urandom_range(0, 24);
      for (int c = 0; c < m; c++) advance(1'($urandom_range(0, 3) != 0));
      settle();
    end
    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
